// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
//   256 x 32 RAM shared by two datapath masters. Each master has its own write
//   port and its own read port (four independent address buses in total), all
//   on one clock. Reads are registered with one cycle of latency.
//
//   Port A owns the word on addr_wr_a every cycle: a port B write to the same
//   address is dropped, whether or not A is actually writing.
//
//   Optional feature (compile-time macro DUAL_PORT_RAM_RD_BYPASS_EN):
//     undefined - read-first: a read of a word being written returns the old
//                 contents; no forwarding logic exists.
//     defined   - write-first: a read of a word committed on the same edge
//                 returns the committed data (A's data if A wrote it, else B's
//                 if B's write was accepted). Dropped B writes never forward.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset of the read
//                           registers only; writes are ignored while high
//   addr_a     in   ADDR_W  port A read address
//   addr_b     in   ADDR_W  port B read address
//   addr_wr_a  in   ADDR_W  port A write address
//   addr_wr_b  in   ADDR_W  port B write address
//   data_in_a  in   DATA_W  port A write data
//   data_in_b  in   DATA_W  port B write data
//   we_a       in   1       port A write enable
//   we_b       in   1       port B write enable
//   data_a     out  DATA_W  port A registered read data
//   data_b     out  DATA_W  port B registered read data
// -----------------------------------------------------------------------------
module dual_port_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [ADDR_W-1:0] addr_wr_a,
   input  logic [ADDR_W-1:0] addr_wr_b,
   input  logic [DATA_W-1:0] data_in_a,
   input  logic [DATA_W-1:0] data_in_b,
   input  logic              we_a,
   input  logic              we_b,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b
);

   localparam int DEPTH = 1 << ADDR_W;

   // Storage comes up all-zero through its initial contents; reset never
   // touches it.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   // Qualified write strobes. B loses any address collision with A's write
   // address, independent of we_a.
   logic wr_en_a;
   logic wr_en_b;

   assign wr_en_a = we_a & ~rst;
   assign wr_en_b = we_b & ~rst & (addr_wr_b != addr_wr_a);

   always_ff @(posedge clk) begin
      if (wr_en_a) begin
         mem[addr_wr_a] <= data_in_a;
      end
      if (wr_en_b) begin
         mem[addr_wr_b] <= data_in_b;
      end
   end

   // Read ports: index 0 is port A, index 1 is port B.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic [ADDR_W-1:0] rd_addr;
         logic [DATA_W-1:0] rd_next;
         logic [DATA_W-1:0] data_reg;

         assign rd_addr = (gi == 0) ? addr_a : addr_b;

`ifdef DUAL_PORT_RAM_RD_BYPASS_EN
         // Forward whatever this edge commits to the addressed word; A wins
         // because B can never be accepted on A's write address anyway.
         always_comb begin
            rd_next = mem[rd_addr];
            if (wr_en_a && (rd_addr == addr_wr_a)) begin
               rd_next = data_in_a;
            end else if (wr_en_b && (rd_addr == addr_wr_b)) begin
               rd_next = data_in_b;
            end
         end
`else
         assign rd_next = mem[rd_addr];
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_reg <= '0;
            end else begin
               data_reg <= rd_next;
            end
         end
      end
   endgenerate

   assign data_a = g_rd[0].data_reg;
   assign data_b = g_rd[1].data_reg;

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  addr_a = '0;
   logic [7:0]  addr_b = '0;
   logic [7:0]  addr_wr_a = '0;
   logic [7:0]  addr_wr_b = '0;
   logic [31:0] data_in_a = '0;
   logic [31:0] data_in_b = '0;
   logic        we_a = 1'b0;
   logic        we_b = 1'b0;
   logic [31:0] data_a;
   logic [31:0] data_b;

   dual_port_ram dut (
      .clk       (clk),
      .rst       (rst),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .addr_wr_a (addr_wr_a),
      .addr_wr_b (addr_wr_b),
      .data_in_a (data_in_a),
      .data_in_b (data_in_b),
      .we_a      (we_a),
      .we_b      (we_b),
      .data_a    (data_a),
      .data_b    (data_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          port;   // 0 = data_a, 1 = data_b
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] obs;
   int          checks = 0;
   int          passes = 0;
   logic [31:0] model [256];

   task automatic push(input bit port, input logic [31:0] val, input string name);
      exp_t x;
      x.port = port;
      x.val  = val;
      x.name = name;
      sb.push_back(x);
   endtask

   task automatic idle();
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   // Power-up zero contents, reset clearing outputs, writes ignored under reset
   task automatic test_reset();
      #2;
      push(0, 32'h0, "reset_a");
      push(1, 32'h0, "reset_b");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
      @(negedge clk);
      addr_wr_a = 8'h07; data_in_a = 32'h0BAD0BAD; we_a = 1'b1;
      @(negedge clk);
      idle();
      rst = 1'b0;
      addr_a = 8'h07; addr_b = 8'h07;
      push(0, 32'h0, "wr_under_rst_a");
      push(1, 32'h0, "wr_under_rst_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   task automatic test_write_a();
      @(negedge clk);
      addr_wr_a = 8'h01; data_in_a = 32'hA5A5A5A5; we_a = 1'b1; addr_a = 8'h02;
      @(negedge clk);
      idle();
      addr_a = 8'h01;
      push(0, 32'hA5A5A5A5, "write_a");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   // B write onto A's write address is dropped even with we_a low, and is never forwarded
   task automatic test_drop_b();
      @(negedge clk);
      addr_wr_a = 8'h01; we_a = 1'b0;
      addr_wr_b = 8'h01; data_in_b = 32'h5A5A5A5A; we_b = 1'b1;
      addr_a = 8'h01; addr_b = 8'h01;
      push(0, 32'hA5A5A5A5, "drop_b_same_edge_a");
      push(1, 32'hA5A5A5A5, "drop_b_same_edge_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
      @(negedge clk);
      idle();
      push(0, 32'hA5A5A5A5, "drop_b_after_a");
      push(1, 32'hA5A5A5A5, "drop_b_after_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   task automatic test_write_b();
      @(negedge clk);
      addr_wr_a = 8'h10; we_a = 1'b0;
      addr_wr_b = 8'h20; data_in_b = 32'h12345678; we_b = 1'b1;
      @(negedge clk);
      idle();
      addr_a = 8'h10; addr_b = 8'h20;
      push(0, 32'h0, "write_b_other_word");
      push(1, 32'h12345678, "write_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   // Both ports write distinct words, then both write the same word (A wins)
   task automatic test_simultaneous();
      @(negedge clk);
      addr_wr_a = 8'hFF; data_in_a = 32'h11111111; we_a = 1'b1;
      addr_wr_b = 8'h00; data_in_b = 32'h22222222; we_b = 1'b1;
      @(negedge clk);
      addr_wr_a = 8'h30; data_in_a = 32'hAAAA0001;
      addr_wr_b = 8'h30; data_in_b = 32'hBBBB0002;
      addr_a = 8'hFF; addr_b = 8'h00;
      push(0, 32'h11111111, "simul_a_ff");
      push(1, 32'h22222222, "simul_b_00");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
      @(negedge clk);
      idle();
      addr_a = 8'h30; addr_b = 8'h30;
      push(0, 32'hAAAA0001, "collide_a_wins_a");
      push(1, 32'hAAAA0001, "collide_a_wins_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   // Read-during-write on A's write address and on B's accepted write address
   task automatic test_rdw();
      @(negedge clk);
      addr_wr_a = 8'h05; data_in_a = 32'hDEADBEEF; we_a = 1'b1;
      addr_wr_b = 8'h06; data_in_b = 32'hCAFEF00D; we_b = 1'b1;
      addr_a = 8'h05; addr_b = 8'h06;
`ifdef DUAL_PORT_RAM_RD_BYPASS_EN
      push(0, 32'hDEADBEEF, "rdw_a_same_edge");
      push(1, 32'hCAFEF00D, "rdw_b_same_edge");
`else
      push(0, 32'h0, "rdw_a_same_edge");
      push(1, 32'h0, "rdw_b_same_edge");
`endif
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
      @(negedge clk);
      idle();
      addr_a = 8'h06; addr_b = 8'h05;
      push(0, 32'hCAFEF00D, "rdw_next_a");
      push(1, 32'hDEADBEEF, "rdw_next_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   // Streaming writes on both ports while each port reads the word written last cycle
   task automatic test_back_to_back();
      logic [31:0] da;
      logic [31:0] db;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         da = $urandom;
         db = $urandom;
         addr_wr_a = 8'(8'h40 + i); data_in_a = da; we_a = 1'b1;
         addr_wr_b = 8'(8'h80 + i); data_in_b = db; we_b = 1'b1;
         addr_a = 8'(8'h3F + i);
         addr_b = 8'(8'h7F + i);
         if (i > 0) begin
            push(0, model[addr_a], "b2b_a");
            push(1, model[addr_b], "b2b_b");
         end
         model[addr_wr_a] = da;
         model[addr_wr_b] = db;
         @(posedge clk); #1;
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
            if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            else passes++;
         end
      end
      @(negedge clk);
      idle();
   endtask

   // Reset between edges clears outputs at once; contents survive; release edge is live
   task automatic test_reset_midrun();
      @(negedge clk);
      addr_a = 8'hFF; addr_b = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      #1;
      push(0, 32'h0, "midrun_rst_a");
      push(1, 32'h0, "midrun_rst_b");
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
      @(negedge clk);
      addr_wr_a = 8'hFF; data_in_a = 32'h0BAD0BAD; we_a = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      we_a = 1'b0;
      addr_wr_a = 8'h00;
      addr_wr_b = 8'h90; data_in_b = 32'h90909090; we_b = 1'b1;
      push(0, 32'h11111111, "after_rst_a");
      push(1, 32'h22222222, "after_rst_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
      @(negedge clk);
      idle();
      addr_a = 8'h90; addr_b = 8'h90;
      push(0, 32'h90909090, "release_edge_write_a");
      push(1, 32'h90909090, "release_edge_write_b");
      @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = e.port ? data_b : data_a; checks++;
         if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
         else passes++;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
      test_reset();
      test_write_a();
      test_drop_b();
      test_write_b();
      test_simultaneous();
      test_rdw();
      test_back_to_back();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
